// File: rtl/cmd_parser.sv
// ASCII command parser: single-key mode selects plus F/A/P numeric commands
// that load the DDS frequency, amplitude and phase registers.
module cmd_parser #(
    parameter int NUM_MODES   = 4,
    parameter int STATE_W     = 5,
    parameter int STOP_CODE   = 10,
    parameter int RESET_STATE = 3,
    parameter int FREQ_W      = 14,
    parameter int AMP_W       = 8,
    parameter int PHASE_W     = 8,
    parameter int FREQ_RST    = 1000,
    parameter int AMP_RST     = 255,
    parameter int PHASE_RST   = 0,
    parameter int MAX_DIGITS  = 5
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_valid,
    output logic [STATE_W-1:0] o_state,
    output logic [FREQ_W-1:0]  o_state_freq,
    output logic [AMP_W-1:0]   o_state_amp,
    output logic [PHASE_W-1:0] o_state_phase,
    output logic               o_cfg_update,
    output logic               o_cmd_err,
    output logic               o_busy
);
    localparam int ACC_W = 20;
    localparam logic [7:0] CH_0 = 8'h30;
    localparam logic [7:0] MODE_MAX_CH = 8'(48 + NUM_MODES);
    localparam logic [ACC_W-1:0] FREQ_MAX  = ACC_W'((1 << FREQ_W) - 1);
    localparam logic [ACC_W-1:0] AMP_MAX   = ACC_W'((1 << AMP_W) - 1);
    localparam logic [ACC_W-1:0] PHASE_MAX = ACC_W'((1 << PHASE_W) - 1);

    typedef enum logic [1:0] {S_IDLE, S_NUM, S_DISCARD} fsm_t;
    typedef enum logic [1:0] {T_FREQ, T_AMP, T_PHASE} tgt_t;

    fsm_t               r_fsm, w_fsm_next;
    tgt_t               r_tgt, w_tgt_next;
    logic [ACC_W-1:0]   r_acc, w_acc_next;
    logic [2:0]         r_cnt, w_cnt_next;
    logic [STATE_W-1:0] r_state, w_state_next;
    logic [FREQ_W-1:0]  r_freq, w_freq_next;
    logic [AMP_W-1:0]   r_amp, w_amp_next;
    logic [PHASE_W-1:0] r_phase, w_phase_next;
    logic               r_upd, w_upd_next;
    logic               r_err, w_err_next;

    logic w_is_digit, w_is_mode, w_is_term, w_is_esc;
    logic [FREQ_W-1:0]  w_freq_clamp;
    logic [AMP_W-1:0]   w_amp_clamp;
    logic [PHASE_W-1:0] w_phase_clamp;
    logic [ACC_W-1:0]   w_acc_shift;

    assign w_is_digit = (i_rx_data >= CH_0) && (i_rx_data <= 8'h39);
    assign w_is_mode  = (i_rx_data >= 8'h31) && (i_rx_data <= MODE_MAX_CH);
    assign w_is_term  = (i_rx_data == 8'd13) || (i_rx_data == 8'd10);
    assign w_is_esc   = (i_rx_data == 8'd27);

    // ASCII digits carry their value in the low nibble
    assign w_acc_shift = (r_acc * ACC_W'(10)) + {{(ACC_W-4){1'b0}}, i_rx_data[3:0]};

    assign w_freq_clamp  = (r_acc > FREQ_MAX)  ? FREQ_MAX[FREQ_W-1:0]   : r_acc[FREQ_W-1:0];
    assign w_amp_clamp   = (r_acc > AMP_MAX)   ? AMP_MAX[AMP_W-1:0]     : r_acc[AMP_W-1:0];
    assign w_phase_clamp = (r_acc > PHASE_MAX) ? PHASE_MAX[PHASE_W-1:0] : r_acc[PHASE_W-1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fsm   <= S_IDLE;
            r_tgt   <= T_FREQ;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= STATE_W'(RESET_STATE);
            r_freq  <= FREQ_W'(FREQ_RST);
            r_amp   <= AMP_W'(AMP_RST);
            r_phase <= PHASE_W'(PHASE_RST);
            r_upd   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_fsm   <= w_fsm_next;
            r_tgt   <= w_tgt_next;
            r_acc   <= w_acc_next;
            r_cnt   <= w_cnt_next;
            r_state <= w_state_next;
            r_freq  <= w_freq_next;
            r_amp   <= w_amp_next;
            r_phase <= w_phase_next;
            r_upd   <= w_upd_next;
            r_err   <= w_err_next;
        end
    end

    always_comb begin
        w_fsm_next   = r_fsm;
        w_tgt_next   = r_tgt;
        w_acc_next   = r_acc;
        w_cnt_next   = r_cnt;
        w_state_next = r_state;
        w_freq_next  = r_freq;
        w_amp_next   = r_amp;
        w_phase_next = r_phase;
        w_upd_next   = 1'b0;
        w_err_next   = 1'b0;
        if (i_rx_valid) begin
            case (r_fsm)
                S_IDLE: begin
                    w_acc_next = '0;
                    w_cnt_next = '0;
                    if (w_is_mode) begin
                        w_state_next = STATE_W'(i_rx_data - 8'd49);
                        w_upd_next   = 1'b1;
                    end else if (i_rx_data == CH_0) begin
                        w_state_next = STATE_W'(STOP_CODE);
                        w_upd_next   = 1'b1;
                    end else if (i_rx_data == 8'h46 || i_rx_data == 8'h66) begin
                        w_tgt_next = T_FREQ;
                        w_fsm_next = S_NUM;
                    end else if (i_rx_data == 8'h41 || i_rx_data == 8'h61) begin
                        w_tgt_next = T_AMP;
                        w_fsm_next = S_NUM;
                    end else if (i_rx_data == 8'h50 || i_rx_data == 8'h70) begin
                        w_tgt_next = T_PHASE;
                        w_fsm_next = S_NUM;
                    end
                end
                S_NUM: begin
                    if (w_is_digit) begin
                        if (r_cnt == 3'(MAX_DIGITS)) begin
                            w_err_next = 1'b1;
                            w_fsm_next = S_DISCARD;
                        end else begin
                            w_acc_next = w_acc_shift;
                            w_cnt_next = r_cnt + 3'd1;
                        end
                    end else if (w_is_term) begin
                        w_fsm_next = S_IDLE;
                        if (r_cnt == 3'd0) begin
                            w_err_next = 1'b1;
                        end else begin
                            w_upd_next = 1'b1;
                            case (r_tgt)
                                T_FREQ:  w_freq_next  = w_freq_clamp;
                                T_AMP:   w_amp_next   = w_amp_clamp;
                                T_PHASE: w_phase_next = w_phase_clamp;
                                default: w_upd_next   = 1'b0;
                            endcase
                        end
                    end else if (w_is_esc) begin
                        w_fsm_next = S_IDLE;
                    end else begin
                        w_err_next = 1'b1;
                        w_fsm_next = S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (w_is_term || w_is_esc) w_fsm_next = S_IDLE;
                end
                default: w_fsm_next = S_IDLE;
            endcase
        end
    end

    assign o_state       = r_state;
    assign o_state_freq  = r_freq;
    assign o_state_amp   = r_amp;
    assign o_state_phase = r_phase;
    assign o_cfg_update  = r_upd;
    assign o_cmd_err     = r_err;
    assign o_busy        = (r_fsm != S_IDLE);
endmodule

// File: doc/cmd_parser.md
Name: cmd_parser

Overview:
- Parametrised successor to the single-character UART mode decoder.
- Consumes ASCII bytes from the UART receiver and decodes single-character mode selects (waveform/stop).
- Also parses multi-character numeric commands that load the frequency, amplitude and phase control registers.
- Sits between the UART RX block and the DDS/waveform generator, and drives all of its configuration registers.

Parameters:
- NUM_MODES, 4: number of selectable waveform modes. Keys '1'..('0'+NUM_MODES) map to mode 0..NUM_MODES-1. Legal range 1..9.
- STATE_W, 5: width of state.
- STOP_CODE, 10: state value loaded by key '0'.
- RESET_STATE, 3: state value after reset.
- FREQ_W, 14: width of state_freq.
- AMP_W, 8: width of state_amp.
- PHASE_W, 8: width of state_phase.
- FREQ_RST, 1000: reset value of state_freq.
- AMP_RST, 255: reset value of state_amp.
- PHASE_RST, 0: reset value of state_phase.
- MAX_DIGITS, 5: maximum decimal digits per number. Legal range 1..6.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- rx_data  input  8  received ASCII byte.
- rx_valid  input  1  one-cycle strobe; rx_data is valid in this cycle. May be asserted every cycle.
- state  output  STATE_W  selected waveform mode / stop code.
- state_freq  output  FREQ_W  frequency control word.
- state_amp  output  AMP_W  amplitude control word.
- state_phase  output  PHASE_W  phase offset word.
- cfg_update  output  1  one-cycle pulse, high in the cycle any of the four registers changes due to a command.
- cmd_err  output  1  one-cycle pulse when a numeric command is rejected.
- busy  output  1  high while the FSM is outside IDLE.

Behaviour:
- Reset (rst_n=0, asynchronous): state=RESET_STATE, state_freq=FREQ_RST, state_amp=AMP_RST, state_phase=PHASE_RST, cfg_update=0, cmd_err=0, busy=0, FSM=IDLE, accumulator=0, digit count=0. Reset asserted mid-command discards the partial command.
- Bytes are processed only in cycles with rx_valid=1. All register outputs update on the clk edge that samples the byte (1-cycle latency). cfg_update/cmd_err are registered and coincide with that update.
- FSM states: IDLE, NUM, DISCARD.
- IDLE:
  - '1'..('0'+NUM_MODES): state <= byte-49, cfg_update=1.
  - '0': state <= STOP_CODE, cfg_update=1.
  - 'F'/'f', 'A'/'a', 'P'/'p': latch target (FREQ/AMP/PHASE), clear accumulator and digit count, go to NUM.
  - Digits above NUM_MODES, CR(13), LF(10), ESC(27) and all other bytes: ignored, no pulse.
- NUM:
  - Digit '0'..'9' with count<MAX_DIGITS: acc <= acc*10 + (byte-48), count+1. The accumulator is 20 bits; 999999 fits, so no internal overflow.
  - Digit with count==MAX_DIGITS: cmd_err=1, go to DISCARD.
  - CR or LF with count>=1: load target <= min(acc, 2^W-1) for the target's width W. cfg_update=1 even if the value is unchanged. Go to IDLE.
  - CR or LF with count==0: cmd_err=1, no load, go to IDLE.
  - ESC: abort to IDLE, no pulse, no load.
  - Any other byte, including a new command letter: cmd_err=1, go to DISCARD.
- DISCARD: ignore all bytes until CR, LF or ESC, then go to IDLE with no further pulse.
- busy=1 in NUM and DISCARD.
- Mode selects are not honoured inside NUM/DISCARD: digits there are number digits.
- cfg_update and cmd_err are never high in the same cycle.
- Leading zeros count toward MAX_DIGITS.
- Bytes arriving on consecutive cycles are all processed; none are dropped.

Test Plan:
- Reset with default parameters -> state=3, state_freq=1000, state_amp=255, state_phase=0, busy=0, no pulses.
- Bytes '2','0','4' spaced 3 cycles apart -> state=1, then 10, then 3, each 1 cycle after its rx_valid with a cfg_update pulse. Byte '7' afterwards -> no change, no pulse.
- Back-to-back bytes 'F','1','2','3','4',CR -> state_freq=1234 and cfg_update=1 one cycle after CR; busy high from cycle after 'F' until cycle after CR.
- Clamping: 'F','2','0','0','0','0',LF -> state_freq=16383; 'a','3','0','0',CR -> state_amp=255; 'P','0','0','0','0','0','9' -> cmd_err after the 6th digit, then CR -> state_phase unchanged, no cfg_update.
- Errors: 'A',CR -> cmd_err, state_amp unchanged. 'P','1','x','5',CR -> cmd_err on 'x', state_phase unchanged, FSM back in IDLE after CR. 'F','9',ESC -> no pulse, state_freq unchanged, busy=0.
- Reset mid-command: 'F','5','5', then pulse rst_n low asynchronously between clock edges, then CR -> outputs at reset values, CR ignored. Following '1' -> state=0.
